keypad_matrix_scanner: RTL

//  Parametrised ROWSxCOLS matrix-keypad scanner: drives active-low one-hot columns, samples active-low rows,

---
 rtl/keypad_pkg.sv | 26 ++
 rtl/keypad_matrix_scanner_if.sv | 11 +
 rtl/keypad_evt_fifo.sv | 50 +++++
 rtl/keypad_matrix_scanner.sv | 186 ++++++++++++++++++
 4 files changed

// File: rtl/keypad_pkg.sv
// rtl/keypad_pkg.sv - shared constants and helpers for the keypad matrix scanner
package keypad_pkg;

   // Event word is {repeat, press, code}; offsets count upward from the top of the code field.
   localparam int EVT_PRESS  = 0;
   localparam int EVT_REPEAT = 1;

   localparam int   CNT_W    = 4;
   localparam int   REP_W    = 16;
   localparam logic COL_IDLE = 1'b1;
   localparam logic ROW_IDLE = 1'b1;

   typedef enum logic {
      EV_RELEASE = 1'b0,
      EV_PRESS   = 1'b1
   } press_e;

   function automatic int code_w(input int rows, input int cols);
      return $clog2(rows * cols);
   endfunction

   function automatic int idx_w(input int n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/keypad_matrix_scanner_if.sv
// rtl/keypad_matrix_scanner_if.sv - key event stream handshake (valid/ready/data)
interface keypad_matrix_scanner_if #(
   parameter int W = 6
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/keypad_evt_fifo.sv
// rtl/keypad_evt_fifo.sv - synchronous event FIFO, simultaneous push/pop allowed when full
module keypad_evt_fifo #(
   parameter int DEPTH = 8,
   parameter int W     = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   localparam int AW = $clog2(DEPTH);

   logic [W-1:0] mem [DEPTH];
   logic [AW-1:0] wr_ptr, rd_ptr;
   logic [AW:0]   count;
   logic          do_push, do_pop;

   assign do_pop  = pop && !empty;
   // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
   assign do_push = push && (!full || do_pop);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= wr_ptr + 1'b1;
         end
         if (do_pop) rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   assign dout  = mem[rd_ptr];
   assign full  = (count == (AW+1)'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/keypad_matrix_scanner.sv
// rtl/keypad_matrix_scanner.sv - ROWSxCOLS keypad scanner with per-key debounce and event FIFO
// Optional auto-repeat of the last pressed key under `KEYPAD_REPEAT_EN.
module keypad_matrix_scanner
   import keypad_pkg::*;
#(
   parameter int ROWS       = 4,
   parameter int COLS       = 4,
   parameter int SCAN_DIV   = 2048,
   parameter int DEBOUNCE   = 4,
   parameter int FIFO_DEPTH = 8,
   parameter int REP_DELAY  = 64,
   parameter int REP_RATE   = 16
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [ROWS-1:0]          row,
   output logic [COLS-1:0]          col,
   keypad_matrix_scanner_if.master  evt,
   output logic                     keydown,
   output logic                     overflow,
   input  logic                     ovf_clr
);
   localparam int K      = ROWS * COLS;
   localparam int CODE_W = code_w(ROWS, COLS);
   localparam int EW     = CODE_W + 2;
   localparam int PW     = idx_w(SCAN_DIV);
   localparam int CW     = idx_w(COLS);
   localparam int RW     = idx_w(ROWS);
   localparam logic [PW-1:0] P_LAST = PW'(SCAN_DIV - 1);
   localparam logic [PW-1:0] P_CAP  = PW'(SCAN_DIV - ROWS - 2);

   logic [PW-1:0] presc;
   logic [CW-1:0] cidx, c_next;

   assign c_next = (cidx == CW'(COLS - 1)) ? '0 : cidx + 1'b1;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         presc <= '0;
         cidx  <= '0;
         col   <= {COLS{COL_IDLE}};
      end else if (presc == P_LAST) begin
         presc <= '0;
         cidx  <= c_next;
         col   <= ~(COLS'(1) << c_next);
      end else begin
         presc <= presc + 1'b1;
         col   <= ~(COLS'(1) << cidx);
      end
   end

   logic [ROWS-1:0] row_m, row_s, row_cap;
   logic [CW-1:0]   cap_col;
   logic [RW-1:0]   walk_r;
   logic            walk_on;

   // Rows are captured late in the slot so the column drive and synchroniser have settled.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         row_m   <= {ROWS{ROW_IDLE}};
         row_s   <= {ROWS{ROW_IDLE}};
         row_cap <= '0;
         cap_col <= '0;
         walk_r  <= '0;
         walk_on <= 1'b0;
      end else begin
         row_m <= row;
         row_s <= row_m;
         if (presc == P_CAP) begin
            row_cap <= ~row_s;
            cap_col <= cidx;
            walk_r  <= '0;
            walk_on <= 1'b1;
         end else if (walk_on) begin
            walk_r <= walk_r + 1'b1;
            if (walk_r == RW'(ROWS - 1)) walk_on <= 1'b0;
         end
      end
   end

   logic [K-1:0]      key_state;
   logic [CNT_W-1:0]  db_cnt [K];
   logic [CODE_W-1:0] code;
   logic              sample, cur, flip;

   assign code   = CODE_W'(int'(cap_col) * ROWS + int'(walk_r));
   assign sample = row_cap[walk_r];
   assign cur    = key_state[code];
   assign flip   = walk_on && (sample != cur) && (db_cnt[code] == CNT_W'(DEBOUNCE - 1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         key_state <= '0;
         for (int i = 0; i < K; i++) db_cnt[i] <= '0;
         keydown   <= 1'b0;
      end else begin
         if (walk_on) begin
            if (sample != cur) begin
               if (flip) begin
                  key_state[code] <= sample;
                  db_cnt[code]    <= '0;
               end else begin
                  db_cnt[code] <= db_cnt[code] + 1'b1;
               end
            end else begin
               db_cnt[code] <= '0;
            end
         end
         keydown <= |key_state;
      end
   end

   logic          push, pop, ovf_set, fifo_full, fifo_empty;
   logic [EW-1:0] din;
   press_e        new_kind;

   assign new_kind = sample ? EV_PRESS : EV_RELEASE;
   assign pop      = evt.valid && evt.ready;

`ifdef KEYPAD_REPEAT_EN
   logic              frame_end, rep_on, rep_first, rep_fire;
   logic [CODE_W-1:0] rep_key;
   logic [REP_W-1:0]  rep_cnt;

   assign frame_end = (presc == P_LAST) && (cidx == CW'(COLS - 1));
   assign rep_fire  = rep_on && frame_end &&
                      ((rep_cnt + 1'b1) == (rep_first ? REP_W'(REP_DELAY) : REP_W'(REP_RATE)));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rep_on    <= 1'b0;
         rep_first <= 1'b0;
         rep_key   <= '0;
         rep_cnt   <= '0;
      end else if (flip && sample) begin
         rep_on    <= 1'b1;
         rep_first <= 1'b1;
         rep_key   <= code;
         rep_cnt   <= '0;
      end else if (flip && (code == rep_key)) begin
         rep_on <= 1'b0;
      end else if (rep_on && frame_end) begin
         if (rep_fire) begin
            rep_cnt   <= '0;
            rep_first <= 1'b0;
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end

   // Key walks never coincide with a frame end, so the two sources never collide.
   assign push    = flip || rep_fire;
   assign din     = flip ? {1'b0, logic'(new_kind), code} : {1'b1, 1'b1, rep_key};
   assign ovf_set = flip && fifo_full && !pop;
`else
   // Repeat bit is constant 0 here; folding in REP_* keeps the parameters referenced.
   localparam logic REP_TIE = (REP_DELAY < 0) || (REP_RATE < 0);

   assign push    = flip;
   assign din     = {REP_TIE, logic'(new_kind), code};
   assign ovf_set = push && fifo_full && !pop;
`endif

   keypad_evt_fifo #(
      .DEPTH (FIFO_DEPTH),
      .W     (EW)
   ) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (push),
      .din   (din),
      .pop   (evt.ready),
      .dout  (evt.data),
      .full  (fifo_full),
      .empty (fifo_empty)
   );

   assign evt.valid = ~fifo_empty;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) overflow <= 1'b0;
      else      overflow <= ovf_set || (overflow && !ovf_clr);
   end

endmodule
